// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH cycles per
// operation, optional two's-complement mode via magnitude multiply + final negate.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            accept, last;
  logic [PW-1:0]   mcand, acc, acc_sum;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic [CW-1:0]   cnt;
  logic            neg;

  // Signed operands are multiplied as magnitudes; -2^(WIDTH-1) maps to itself,
  // which reads correctly as an unsigned WIDTH-bit magnitude.
  assign a_mag   = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag   = (sgn && B[WIDTH-1]) ? -B : B;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == CW'(WIDTH - 1)) begin
        last      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      P      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= '0;
        neg    <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) begin
          P    <= neg ? -acc_sum : acc_sum;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed, handshake, reset and randomized checks at
// WIDTH=8, exhaustive at WIDTH=4, randomized at WIDTH=16, against an arithmetic model.
module tb_seq_multiplier;
  logic clk, rst;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_chk = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8));
  seq_multiplier #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .P(p4));
  seq_multiplier #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .P(p16));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
  function automatic logic [63:0] mul_ref(input bit s, input longint a, input longint b,
                                          input int w);
    longint av, bv, m;
    av = a;
    bv = b;
    if (s && a[w-1]) av = a - (longint'(1) << w);
    if (s && b[w-1]) bv = b - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return 64'((av * bv) & m);
  endfunction

  // Entered #1 after a rising edge; that edge's successor accepts the start.
  task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                     input bit repulse, output logic [15:0] res);
    int k, nb, herr;
    logic [15:0] p0;
    p0 = p8; k = 0; nb = 0; herr = 0;
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; sgn8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && k < 40) begin
      if (busy8) nb++;
      if (p8 !== p0) herr++;
      if (repulse) start8 = (k == 3);
      @(posedge clk); #1;
      k++;
    end
    start8 = 1'b0;
    chk("lat8", k, 8);
    chk("busy_cycles8", nb, 8);
    chk("p_hold8", herr, 0);
    chk("busy_at_done8", busy8, 0);
    res = p8;
  endtask

  task automatic op4(input bit s, input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] res);
    int k;
    k = 0;
    start4 = 1'b1; sgn4 = s; a4 = a; b4 = b;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    while (!done4 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("lat4", k, 4);
    res = p4;
  endtask

  task automatic op16(input bit s, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] res);
    int k;
    k = 0;
    start16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    while (!done16 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("lat16", k, 16);
    res = p16;
  endtask

  // Directed table: sgn, A, B, expected product.
  bit          ds [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  logic [7:0]  da [13] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h05,
                           8'hFF, 8'h80, 8'h80, 8'h05};
  logic [7:0]  db [13] = '{8'h00, 8'h01, 8'h03, 8'h05, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hFD,
                           8'hFF, 8'h80, 8'h7F, 8'hFD};
  logic [15:0] dp [13] = '{16'h0000, 16'h0001, 16'h0006, 16'h0014, 16'hFE01, 16'h0001,
                           16'h4000, 16'hC080, 16'hFFF1, 16'hFE01, 16'h4000, 16'h3F80,
                           16'h04F1};

  initial begin
    logic [15:0] r8;
    logic [7:0]  r4;
    logic [31:0] r16;
    int nd;
    clk = 1'b0; rst = 1'b1;
    start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
    start4 = 0; sgn4 = 0; a4 = '0; b4 = '0;
    start16 = 0; sgn16 = 0; a16 = '0; b16 = '0;
    #12;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_p", p8, 0);
    chk("rst_p4", p4, 0);
    chk("rst_p16", p16, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      op8(ds[i], da[i], db[i], 1'b0, r8);
      chk($sformatf("dir%0d_%0h_%0h", i, da[i], db[i]), r8, dp[i]);
    end
    @(posedge clk); #1;
    chk("done_falls", done8, 0);

    // Re-pulsed start mid-operation is ignored; next start lands in the done cycle.
    op8(1'b0, 8'd3, 8'd4, 1'b1, r8);
    chk("hs_3x4", r8, 16'd12);
    op8(1'b0, 8'd6, 8'd7, 1'b0, r8);
    chk("hs_6x7", r8, 16'd42);
    @(posedge clk); #1;
    chk("single_done", done8, 0);

    // Asynchronous reset in the middle of an operation.
    start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd100;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_p", p8, 0);
    chk("midrst_done", done8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      if (done8) nd++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_p_held", p8, 0);
    op8(1'b0, 8'd10, 8'd10, 1'b0, r8);
    chk("post_rst_10x10", r8, 16'd100);

    for (int i = 0; i < 1000; i++) begin
      bit s;
      logic [7:0] a, b;
      s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      op8(s, a, b, 1'b0, r8);
      chk($sformatf("rnd8 s%0d %0h*%0h", s, a, b), r8, mul_ref(s, a, b, 8));
    end

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          op4(1'(s), 4'(a), 4'(b), r4);
          chk($sformatf("exh4 s%0d %0h*%0h", s, a, b), r4, mul_ref(1'(s), a, b, 4));
        end

    for (int i = 0; i < 300; i++) begin
      bit s;
      logic [15:0] a, b;
      s = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      op16(s, a, b, r16);
      chk($sformatf("rnd16 s%0d %0h*%0h", s, a, b), r16, mul_ref(s, a, b, 16));
    end
    op16(1'b1, 16'h8000, 16'h8000, r16);
    chk("w16_min_sq", r16, 32'h4000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
